// File: rtl/regfile_sched.sv
// Register scoreboard gating issue on RAW/WAW hazards, plus round-robin arbitration
// of the ALU and load writebacks onto the single registered regfile write port.
module regfile_sched #(
  parameter int XW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_ip,
  input  logic          issue_valid_ip,
  input  logic [4:0]    issue_rs1_ip,
  input  logic [4:0]    issue_rs2_ip,
  input  logic [4:0]    issue_rd_ip,
  input  logic          issue_rd_we_ip,
  output logic          issue_ready_op,
  input  logic          wb0_valid_ip,
  input  logic [4:0]    wb0_addr_ip,
  input  logic [XW-1:0] wb0_data_ip,
  output logic          wb0_ready_op,
  input  logic          wb1_valid_ip,
  input  logic [4:0]    wb1_addr_ip,
  input  logic [XW-1:0] wb1_data_ip,
  output logic          wb1_ready_op,
  output logic          rf_wr_en_op,
  output logic [4:0]    rf_wr_addr_op,
  output logic [XW-1:0] rf_wr_data_op,
  output logic [31:0]   busy_op,
  output logic          err_op
);

  logic [31:0]   r_busy;
  logic          r_ptr;
  logic          r_err;
  logic          r_wr_en;
  logic [4:0]    r_wr_addr;
  logic [XW-1:0] r_wr_data;

  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_issue_fire;
  logic [31:0]   w_busy_nxt;

  assign issue_ready_op = !flush_ip & !r_busy[issue_rs1_ip] & !r_busy[issue_rs2_ip] &
                          !(issue_rd_we_ip & r_busy[issue_rd_ip]);
  assign w_issue_fire   = issue_valid_ip & issue_ready_op;

  // r_ptr names the side that wins when both requesters are valid.
  assign w_gnt0 = !flush_ip & wb0_valid_ip & (!wb1_valid_ip | !r_ptr);
  assign w_gnt1 = !flush_ip & wb1_valid_ip & (!wb0_valid_ip | r_ptr);

  assign wb0_ready_op  = w_gnt0;
  assign wb1_ready_op  = w_gnt1;
  assign rf_wr_en_op   = r_wr_en;
  assign rf_wr_addr_op = r_wr_addr;
  assign rf_wr_data_op = r_wr_data;
  assign busy_op       = r_busy;
  assign err_op        = r_err;

  always_comb begin
    w_busy_nxt = r_busy;
    if (r_wr_en) w_busy_nxt[r_wr_addr] = 1'b0;
    if (w_issue_fire & issue_rd_we_ip) w_busy_nxt[issue_rd_ip] = 1'b1;
    if (flush_ip) w_busy_nxt = '0;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy    <= '0;
      r_ptr     <= 1'b0;
      r_err     <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      // A write landing during a flush hits a register the flush is clearing anyway.
      if (r_wr_en & !flush_ip & !r_busy[r_wr_addr]) r_err <= 1'b1;
      if (w_gnt0) begin
        r_wr_en   <= |wb0_addr_ip;
        r_wr_addr <= wb0_addr_ip;
        r_wr_data <= wb0_data_ip;
        r_ptr     <= 1'b1;
      end else if (w_gnt1) begin
        r_wr_en   <= |wb1_addr_ip;
        r_wr_addr <= wb1_addr_ip;
        r_wr_data <= wb1_data_ip;
        r_ptr     <= 1'b0;
      end else begin
        r_wr_en <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_sched.sv
// Randomized and directed bench for regfile_sched against a behavioural scoreboard model.
module tb_regfile_sched;
  localparam int XW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          iv;
  logic [4:0]    rs1, rs2, rd;
  logic          rdwe;
  logic          iready;
  logic          v0, v1;
  logic [4:0]    a0, a1;
  logic [XW-1:0] d0, d1;
  logic          r0, r1;
  logic          wen;
  logic [4:0]    waddr;
  logic [XW-1:0] wdata;
  logic [31:0]   busy;
  logic          err;

  regfile_sched #(.XW(XW)) dut (
    .clk(clk), .rst(rst), .flush_ip(flush),
    .issue_valid_ip(iv), .issue_rs1_ip(rs1), .issue_rs2_ip(rs2),
    .issue_rd_ip(rd), .issue_rd_we_ip(rdwe), .issue_ready_op(iready),
    .wb0_valid_ip(v0), .wb0_addr_ip(a0), .wb0_data_ip(d0), .wb0_ready_op(r0),
    .wb1_valid_ip(v1), .wb1_addr_ip(a1), .wb1_data_ip(d1), .wb1_ready_op(r1),
    .rf_wr_en_op(wen), .rf_wr_addr_op(waddr), .rf_wr_data_op(wdata),
    .busy_op(busy), .err_op(err)
  );

  always #5 clk = ~clk;

  // Model: set of busy registers, the write sitting on the port, preferred requester.
  logic [31:0]   m_busy;
  logic          m_err;
  logic          m_en;
  logic [4:0]    m_addr;
  logic [XW-1:0] m_data;
  int            m_pref;
  int            last_g;
  int            n_cmp = 0;
  int            n_fail = 0;
  bit            cmp_on = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit reg_busy(input logic [4:0] r);
    return (r != 5'd0) && m_busy[r];
  endfunction

  function automatic bit exp_iready();
    return !flush && !reg_busy(rs1) && !reg_busy(rs2) && !(rdwe && reg_busy(rd));
  endfunction

  function automatic int exp_grant();
    if (flush) return -1;
    if (v0 && v1) return m_pref;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = '0; m_err = 0; m_en = 0; m_addr = '0; m_data = '0; m_pref = 0; last_g = -1;
  endtask

  task automatic model_edge();
    int g;
    bit fire;
    logic [31:0] nb;
    g = exp_grant();
    fire = iv && exp_iready();
    if (m_en && !flush && !reg_busy(m_addr)) m_err = 1;
    nb = m_busy;
    if (m_en) nb[m_addr] = 1'b0;
    if (fire && rdwe && rd != 5'd0) nb[rd] = 1'b1;
    if (flush) nb = '0;
    m_busy = nb;
    if (g == 0) begin
      m_en = (a0 != 5'd0); m_addr = a0; m_data = d0; m_pref = 1;
    end else if (g == 1) begin
      m_en = (a1 != 5'd0); m_addr = a1; m_data = d1; m_pref = 0;
    end else begin
      m_en = 0;
    end
    last_g = g;
  endtask

  task automatic compare_all();
    int g;
    g = exp_grant();
    chk("issue_ready", iready, exp_iready());
    chk("wb0_ready", r0, g == 0);
    chk("wb1_ready", r1, g == 1);
    chk("rf_wr_en", wen, m_en);
    if (m_en) begin
      chk("rf_wr_addr", waddr, m_addr);
      chk("rf_wr_data", wdata, m_data);
    end
    chk("busy", busy, m_busy);
    chk("err", err, m_err);
  endtask

  always @(negedge clk) if (cmp_on) compare_all();

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    flush = 0; iv = 0; rs1 = 0; rs2 = 0; rd = 0; rdwe = 0;
    v0 = 0; a0 = 0; d0 = 0; v1 = 0; a1 = 0; d1 = 0;
  endtask

  task automatic do_reset();
    cmp_on = 0;
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    model_reset();
    #1;
  endtask

  task automatic issue_rd(input logic [4:0] r);
    iv = 1; rs1 = 0; rs2 = 0; rd = r; rdwe = 1;
    step();
    iv = 0;
  endtask

  function automatic logic [4:0] pick_addr();
    logic [4:0] c;
    c = 5'($urandom_range(31, 0));
    if ($urandom_range(3, 0) != 0) begin
      for (int k = 0; k < 32; k++)
        if (reg_busy(5'(c + k))) return 5'(c + k);
    end
    return c;
  endfunction

  initial begin
    logic [4:0] exp_addr [4];
    exp_addr[0] = 5'd1; exp_addr[1] = 5'd2; exp_addr[2] = 5'd3; exp_addr[3] = 5'd4;

    // Reset state and idle hazard check.
    do_reset();
    chk("rst_busy", busy, 32'h0);
    chk("rst_wr_en", wen, 1'b0);
    chk("rst_wr_addr", waddr, 5'd0);
    chk("rst_wr_data", wdata, 32'h0);
    chk("rst_err", err, 1'b0);
    rs1 = 5'd3; rs2 = 5'd4; rd = 5'd5; rdwe = 1;
    #1 chk("idle_issue_ready", iready, 1'b1);
    idle_inputs();
    cmp_on = 1;

    // Issue x5, write it back via wb0 in cycle 3.
    issue_rd(5'd5);
    chk("busy5_set", busy[5], 1'b1);
    step(); step();
    v0 = 1; a0 = 5'd5; d0 = 32'hDEADBEEF;
    #1 chk("wb0_grant_c3", r0, 1'b1);
    step();
    v0 = 0;
    chk("wr_en_c4", wen, 1'b1);
    chk("wr_addr_c4", waddr, 5'd5);
    chk("wr_data_c4", wdata, 32'hDEADBEEF);
    step();
    chk("busy5_clr_c5", busy[5], 1'b0);

    // RAW / WAW stalls on x7; x0 never stalls.
    issue_rd(5'd7);
    rs1 = 0; rs2 = 5'd7; rd = 5'd3; rdwe = 1;
    #1 chk("raw_stall", iready, 1'b0);
    rs2 = 0; rd = 5'd7;
    #1 chk("waw_stall", iready, 1'b0);
    rd = 5'd3;
    #1 chk("x0_no_stall", iready, 1'b1);
    v1 = 1; a1 = 5'd7; d1 = 32'h1234_5678;
    step();
    v1 = 0; rs2 = 5'd7;
    #1 chk("raw_stall_commit_cycle", iready, 1'b0);
    step();
    chk("raw_release", iready, 1'b1);
    idle_inputs();

    // Round robin with both requesters valid every cycle.
    do_reset();
    cmp_on = 1;
    for (int r = 1; r <= 4; r++) issue_rd(5'(r));
    v0 = 1; a0 = 5'd1; d0 = 32'hA1; v1 = 1; a1 = 5'd2; d1 = 32'hB2;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_wb0", r0, (i % 2) == 0);
      chk("rr_wb1", r1, (i % 2) == 1);
      step();
      if (i > 0 || wen) chk("rr_addr", waddr, exp_addr[i]);
      if (i == 0) begin a0 = 5'd3; d0 = 32'hA3; end
      if (i == 1) begin a1 = 5'd4; d1 = 32'hB4; end
    end
    v0 = 0; v1 = 0;
    step();

    // Flush with wb0 pending and a write already on the port.
    issue_rd(5'd3); issue_rd(5'd4);
    v0 = 1; a0 = 5'd3; d0 = 32'h33;
    step();
    a0 = 5'd4; d0 = 32'h44; flush = 1;
    #1 chk("flush_no_grant", r0, 1'b0);
    step();
    flush = 0; v0 = 0;
    chk("flush_busy_clr", busy, 32'h0);
    chk("flush_no_err", err, 1'b0);

    // Write to a non-busy register, then a writeback to x0.
    v1 = 1; a1 = 5'd9; d1 = 32'h99;
    step();
    v1 = 0;
    chk("err_write_en", wen, 1'b1);
    step();
    chk("err_set", err, 1'b1);
    step(); step();
    chk("err_sticky", err, 1'b1);
    v0 = 1; a0 = 5'd0; d0 = 32'h5;
    #1 chk("x0_wb_ready", r0, 1'b1);
    step();
    v0 = 0;
    chk("x0_no_write", wen, 1'b0);

    // Randomized traffic, requesters hold until granted.
    do_reset();
    cmp_on = 1;
    for (int c = 0; c < 3000; c++) begin
      flush = ($urandom_range(24, 0) == 0);
      iv = $urandom_range(1, 0);
      rs1 = 5'($urandom_range(7, 0)); rs2 = 5'($urandom_range(7, 0));
      rd = 5'($urandom_range(7, 0)); rdwe = $urandom_range(1, 0);
      if (!v0 && $urandom_range(2, 0) == 0) begin v0 = 1; a0 = pick_addr(); d0 = $urandom; end
      if (!v1 && $urandom_range(2, 0) == 0) begin v1 = 1; a1 = pick_addr(); d1 = $urandom; end
      step();
      if (last_g == 0 || flush) v0 = 0;
      if (last_g == 1 || flush) v1 = 0;
    end
    idle_inputs();
    step();

    // Asynchronous reset while a write is on the port.
    v0 = 1; a0 = 5'd6; d0 = 32'h66;
    step();
    v0 = 0;
    chk("pre_rst_wr_en", wen, 1'b1);
    cmp_on = 0;
    #1 rst = 1;
    #1;
    chk("async_rst_wr_en", wen, 1'b0);
    chk("async_rst_busy", busy, 32'h0);
    chk("async_rst_err", err, 1'b0);
    #10 rst = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_sched.md
Name: regfile_sched

Overview:
Scheduler in front of the CPU register file. It tracks a busy bit per architectural register and gates instruction issue on RAW/WAW hazards. It also round-robin arbitrates two writeback requesters (wb0 = ALU, wb1 = load unit) onto the register file's single write port. Its registered write outputs drive the regfile write interface directly.

Parameters:
XW, 32, data width of writeback data and the regfile write port

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
flush_ip  input  1  pipeline flush; clears scoreboard
issue_valid_ip  input  1  decode presents an instruction
issue_rs1_ip  input  5  source register 1
issue_rs2_ip  input  5  source register 2
issue_rd_ip  input  5  destination register
issue_rd_we_ip  input  1  instruction writes rd
issue_ready_op  output  1  no hazard; issue may proceed (combinational)
wb0_valid_ip  input  1  ALU writeback request
wb0_addr_ip  input  5  ALU writeback register
wb0_data_ip  input  XW  ALU writeback data
wb0_ready_op  output  1  ALU request granted this cycle (combinational)
wb1_valid_ip  input  1  load writeback request
wb1_addr_ip  input  5  load writeback register
wb1_data_ip  input  XW  load writeback data
wb1_ready_op  output  1  load request granted this cycle (combinational)
rf_wr_en_op  output  1  regfile write enable (registered)
rf_wr_addr_op  output  5  regfile write address (registered)
rf_wr_data_op  output  XW  regfile write data (registered)
busy_op  output  32  scoreboard; bit 0 is constant 0
err_op  output  1  sticky: a write committed to a non-busy register

Behaviour:
- Reset (rst high, asynchronous): busy = 0, rf_wr_en_op/addr/data = 0, err_op = 0, round-robin pointer = wb0. Any in-flight write is dropped.
- Clock and reset: one clock, clk; reset is asynchronous and active-high, rst.
- Hazard check:
  - issue_ready_op = !flush_ip & !busy[rs1] & !busy[rs2] & !(issue_rd_we_ip & busy[rd]).
  - x0 is never busy.
  - issue_ready_op is independent of issue_valid_ip.
- Issue handshake: issue_valid_ip & issue_ready_op. If rd_we & rd != 0, busy[rd] sets at that edge.
- Arbitration:
  - At most one grant per cycle, combinational from the valids and the pointer.
  - Only one valid: it is granted. Both valid: the pointer side is granted.
  - After any grant, the pointer moves to the other requester.
  - During flush_ip, both readies = 0.
  - Requesters hold valid/addr/data stable until ready.
- Write path, grant in cycle N:
  - rf_wr_en_op = 1 in cycle N+1, with the granted addr/data.
  - Grant with addr 0: consumed, rf_wr_en_op = 0 in N+1.
  - No grant: rf_wr_en_op = 0; addr/data hold their last value.
- Busy clear:
  - busy[rf_wr_addr_op] clears at the edge ending the cycle in which rf_wr_en_op = 1.
  - The regfile read is registered, so the earliest dependent issue that reads the new value is cycle N+2.
  - Set and clear in the same cycle always target different registers, because a busy rd stalls issue.
- Error: if rf_wr_en_op = 1 and busy[rf_wr_addr_op] = 0, err_op sets. The write still occurs. err_op clears only on reset.
- Flush:
  - All busy bits clear at the edge ending the flush cycle.
  - No issue and no grants occur in that cycle.
  - A write already on rf_wr_* (granted before the flush) still completes and does not set err_op.
  - Requesters drop their requests themselves.
- Widths: address compare is on the full 5 bits. Data passes through unmodified.

Test Plan:
- Reset then idle → busy_op = 0, rf_wr_en_op = 0, issue_ready_op = 1 for rs1 = 3, rs2 = 4, rd = 5.
- Issue rd = 5 (we = 1), then wb0 valid addr 5 data 0xDEADBEEF in cycle 3:
  - busy[5] = 1 from cycle 1.
  - wb0_ready_op = 1 in cycle 3.
  - rf_wr_en_op = 1, addr 5, data 0xDEADBEEF in cycle 4.
  - busy[5] = 0 in cycle 5.
- RAW stall: busy[7] = 1, issue rs2 = 7 → issue_ready_op = 0 until the cycle after the x7 write commits. WAW with rd = 7 also stalls. rs1 = 0 never stalls.
- Both wb valid every cycle for 4 cycles after reset (regs 1 and 2 busy) → grants wb0, wb1, wb0, wb1; rf_wr_addr_op alternates.
- wb1 write to addr 9 while busy[9] = 0 → write occurs, err_op = 1 and stays 1. Writeback to addr 0 → ready = 1, rf_wr_en_op stays 0.
- Regs 3, 4 busy, flush_ip pulsed while wb0 valid → wb0_ready_op = 0 in the flush cycle; busy_op = 0 next cycle. Assert rst mid-write → rf_wr_en_op drops to 0 immediately.
